bv8_masked_basis_pipe: RTL and testbench
========================================

// Module: bv8_masked_basis_pipe
// PURPOSE
//  Share-wise GF(2)-linear basis change of a d-share masked GF(2^8) value.
//  Per transaction, in_mode selects the forward or the backward 8x8 matrix.
//  Elastic valid/ready pipeline with STAGES register slices.
//  Sits between the masked state datapath and the masked S-box inverter.
//  Used on both the S-box input and output sides.
// PARAMETERS
//  NUM_SHARES  2        number of Boolean shares d (>=1)
//  STAGES      1        pipeline register slices (>=1); also the latency
//  FWD_MATRIX  64'h8040_2010_0804_0201  forward map; row i = FWD_MATRIX[8*i +: 8]
//  BWD_MATRIX  64'h8040_2010_0804_0201  backward map; same row layout (identity default)
// PORTS
//  in_clock   in   1        clock, rising edge
//  in_reset   in   1        synchronous, active-high reset
//  in_valid   in   1        upstream transaction valid
//  out_ready  out  1        block can accept (upstream handshake)
//  in_mode    in   1        0 = FWD_MATRIX, 1 = BWD_MATRIX
//  in_x       in   8*d      share s = in_x[8*s +: 8]
//  out_valid  out  1        result valid
//  in_ready   in   1        downstream accepts
//  out_y      out  8*d      share s = out_y[8*s +: 8]
//  out_mode   out  1        in_mode carried with the result
// BEHAVIOUR
//  - Arithmetic: for each share s and bit i, y_s[i] = ^(ROW_i & x_s).
//    ROW_i is taken from the matrix chosen by in_mode at acceptance.
//    Shares are never mixed, so XOR_s y_s = M * (XOR_s x_s).
//  - Handshake: a transfer happens on a cycle where valid && ready.
//    The producer holds data/mode stable while valid && !ready.
//    out_valid, out_y and out_mode stay stable until taken.
//  - Stage k holds v[k], data[k] and mode[k]. Stage k advances when
//    !v[k+1] || advance[k+1]; the last stage advances when !v[last] || in_ready.
//    out_ready = advance of stage 0, a combinational path from in_ready.
//    No bubble is inserted while all stages are full and in_ready = 1.
//  - The matrix multiply happens before stage 0. Later stages only register.
//  - Latency is exactly STAGES cycles when there is no backpressure.
//    Throughput is 1 transaction/cycle. Order is strictly FIFO.
//    Nothing is ever dropped or duplicated.
//  - A stage that advances with no incoming valid clears its v bit.
//    Its data register keeps its old value; out_y is don't-care when !out_valid.
//  - Reset: every v[k] = 0, every data register = 0, every mode register = 0.
//    So out_valid = 0, out_y = 0, out_mode = 0.
//    out_ready = 1 in the first cycle after reset.
//  - Reset mid-operation flushes all in-flight transactions; none is emitted.
//    Reset wins over a simultaneous handshake.
//  - Mode may change on any consecutive transfer, with no flush and no penalty.
// TESTING
//  1. d=2, STAGES=1, identity matrices; in_x=16'hA553, mode=0 @t0
//     -> out_valid @t1, out_y=16'hA553, out_mode=0.
//  2. FWD rows = rotl1 (ROW_i = 1<<((i+7)%8)), d=1; x=8'h81, mode=0
//     -> y=8'h03. Same x with mode=1 (identity) -> y=8'h81.
//  3. d=3, random shares; check XOR of out shares = M*XOR(in shares).
//     Check each share individually against its per-share reference model.
//  4. STAGES=3, stream 10 items with in_ready held 0 for 5 cycles mid-stream
//     -> out_ready drops once 3 are held. All 10 emerge in order, unchanged.
//     Zero gaps once in_ready returns to 1.
//  5. Assert in_reset with 2 items in flight -> out_valid=0 next cycle.
//     Neither item ever appears. out_ready=1 afterwards.
//  6. Back-to-back transfers with mode alternating 0/1/0 every cycle
//     -> out_mode and out_y follow per item, at 1 item/cycle.

Source files
------------

// File: rtl/bv8_masked_basis_pipe.sv
// Share-wise GF(2) 8x8 basis change on a d-share masked byte, elastic valid/ready pipeline.
// Latency STAGES cycles, 1 item/cycle; out_ready combinationally follows in_ready when all stages are full.
module bv8_masked_basis_pipe #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned STAGES     = 1,
  parameter logic [63:0] FWD_MATRIX = 64'h8040_2010_0804_0201,
  parameter logic [63:0] BWD_MATRIX = 64'h8040_2010_0804_0201
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_valid,
  output logic                    out_ready,
  input  logic                    in_mode,
  input  logic [8*NUM_SHARES-1:0] in_x,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic [8*NUM_SHARES-1:0] out_y,
  output logic                    out_mode
);

  localparam int unsigned W = 8 * NUM_SHARES;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] dat;
  } stage_t;

  logic [63:0]       mat;
  stage_t            mul_d;
  stage_t            stage_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] adv;

  // Each share is multiplied independently so the masking is preserved.
  always_comb begin
    mat        = in_mode ? BWD_MATRIX : FWD_MATRIX;
    mul_d.mode = in_mode;
    mul_d.dat  = '0;
    for (int s = 0; s < NUM_SHARES; s++) begin
      for (int i = 0; i < 8; i++) begin
        mul_d.dat[8*s+i] = ^(mat[8*i +: 8] & in_x[8*s +: 8]);
      end
    end
  end

  // A stage can load when any stage from it to the output is empty, or the sink takes.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = in_ready || (|((~vld_q) >> k));
    end
  end

  assign out_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic   up_v;
    stage_t up_d;
    logic   v_q;
    stage_t d_q;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = mul_d;
    end else begin : g_body
      assign up_v = vld_q[k-1];
      assign up_d = stage_q[k-1];
    end

    always_ff @(posedge in_clock) begin
      if (in_reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (adv[k]) begin
        v_q <= up_v;
        if (up_v) begin
          d_q <= up_d;
        end
      end
    end

    assign vld_q[k]   = v_q;
    assign stage_q[k] = d_q;
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_y     = stage_q[STAGES-1].dat;
  assign out_mode  = stage_q[STAGES-1].mode;

endmodule

// File: tb/tb_bv8_masked_basis_pipe.sv
// Bench for bv8_masked_basis_pipe: three configurations, scoreboard on the 3-share, 3-stage instance.
module tb_bv8_masked_basis_pipe;

  localparam logic [63:0] IDENT = 64'h8040_2010_0804_0201;
  localparam logic [63:0] ROTL  = 64'h4020_1008_0402_0180;
  localparam logic [63:0] DENSE = 64'h1F3E_7CF8_F1E3_C78F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Instance A: 2 shares, 1 stage, identity matrices
  logic        a_in_valid, a_out_ready, a_in_mode, a_out_valid, a_in_ready, a_out_mode;
  logic [15:0] a_in_x, a_out_y;
  // Instance B: 1 share, 1 stage, FWD = rotate-left-by-1, BWD = identity
  logic        b_in_valid, b_out_ready, b_in_mode, b_out_valid, b_in_ready, b_out_mode;
  logic [7:0]  b_in_x, b_out_y;
  // Instance C: 3 shares, 3 stages, FWD = dense, BWD = rotate-left-by-1
  logic        c_in_valid, c_out_ready, c_in_mode, c_out_valid, c_in_ready, c_out_mode;
  logic [23:0] c_in_x, c_out_y;

  bv8_masked_basis_pipe #(.NUM_SHARES(2), .STAGES(1), .FWD_MATRIX(IDENT), .BWD_MATRIX(IDENT)) dut_a (
    .in_clock(clk), .in_reset(rst), .in_valid(a_in_valid), .out_ready(a_out_ready),
    .in_mode(a_in_mode), .in_x(a_in_x), .out_valid(a_out_valid), .in_ready(a_in_ready),
    .out_y(a_out_y), .out_mode(a_out_mode));

  bv8_masked_basis_pipe #(.NUM_SHARES(1), .STAGES(1), .FWD_MATRIX(ROTL), .BWD_MATRIX(IDENT)) dut_b (
    .in_clock(clk), .in_reset(rst), .in_valid(b_in_valid), .out_ready(b_out_ready),
    .in_mode(b_in_mode), .in_x(b_in_x), .out_valid(b_out_valid), .in_ready(b_in_ready),
    .out_y(b_out_y), .out_mode(b_out_mode));

  bv8_masked_basis_pipe #(.NUM_SHARES(3), .STAGES(3), .FWD_MATRIX(DENSE), .BWD_MATRIX(ROTL)) dut_c (
    .in_clock(clk), .in_reset(rst), .in_valid(c_in_valid), .out_ready(c_out_ready),
    .in_mode(c_in_mode), .in_x(c_in_x), .out_valid(c_out_valid), .in_ready(c_in_ready),
    .out_y(c_out_y), .out_mode(c_out_mode));

  typedef struct packed {
    logic        mode;
    logic [23:0] y;
    logic [7:0]  xr;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  bit   mon_en = 1'b0;
  exp_t mon_e;

  // Column-wise reference: y = XOR of matrix columns selected by the set bits of x.
  function automatic logic [7:0] gf2_mul(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) begin
        for (int i = 0; i < 8; i++) y[i] = y[i] ^ m[8*i+j];
      end
    end
    return y;
  endfunction

  function automatic exp_t c_model(input logic [23:0] x, input logic m);
    exp_t       e;
    logic [63:0] mat;
    mat    = m ? ROTL : DENSE;
    e.mode = m;
    e.y    = {gf2_mul(mat, x[23:16]), gf2_mul(mat, x[15:8]), gf2_mul(mat, x[7:0])};
    e.xr   = gf2_mul(mat, x[7:0] ^ x[15:8] ^ x[23:16]);
    return e;
  endfunction

  // Drive one item into C and hold it until accepted; expectation queued at acceptance.
  task automatic c_send(input logic [23:0] x, input logic m);
    int  w;
    bit  done;
    w = 0;
    done = 1'b0;
    c_in_valid = 1'b1;
    c_in_x     = x;
    c_in_mode  = m;
    while (!done) begin
      @(negedge clk);
      if (c_out_ready) begin
        sb.push_back(c_model(x, m));
        done = 1'b1;
      end else if (++w > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: out_ready stuck at 0, required 1 within 200 cycles");
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && c_out_valid && c_in_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y=%h mode=%b, required no output", c_out_y, c_out_mode);
      end else begin
        mon_e = sb.pop_front();
        out_cyc.push_back(cyc);
        checks++;
        if (c_out_mode !== mon_e.mode) begin
          errors++;
          $display("FAIL out_mode: got %b required %b", c_out_mode, mon_e.mode);
        end
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (c_out_y[8*s +: 8] !== mon_e.y[8*s +: 8]) begin
            errors++;
            $display("FAIL share%0d: got %h required %h", s, c_out_y[8*s +: 8], mon_e.y[8*s +: 8]);
          end
        end
        checks++;
        if ((c_out_y[7:0] ^ c_out_y[15:8] ^ c_out_y[23:16]) !== mon_e.xr) begin
          errors++;
          $display("FAIL share_xor: got %h required %h",
                   c_out_y[7:0] ^ c_out_y[15:8] ^ c_out_y[23:16], mon_e.xr);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", c_out_valid); end
    checks++; if (c_out_y !== 24'h0) begin errors++; $display("FAIL reset_out_y: got %h required 000000", c_out_y); end
    checks++; if (c_out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %b required 0", c_out_mode); end
    checks++; if (c_out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready: got %b required 1", c_out_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b required 0", a_out_valid); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b required 0", b_out_valid); end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_identity;
    a_in_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_x     = 16'hA553;
    a_in_mode  = 1'b0;
    @(negedge clk);
    checks++; if (a_out_ready !== 1'b1) begin errors++; $display("FAIL ident_ready: got %b required 1", a_out_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ident_early: got %b required 0", a_out_valid); end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ident_valid: got %b required 1", a_out_valid); end
    checks++; if (a_out_y !== 16'hA553) begin errors++; $display("FAIL ident_y: got %h required a553", a_out_y); end
    checks++; if (a_out_mode !== 1'b0) begin errors++; $display("FAIL ident_mode: got %b required 0", a_out_mode); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ident_dup: got valid %b required 0", a_out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rotl;
    b_in_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_x     = 8'h81;
    b_in_mode  = 1'b0;
    @(posedge clk);
    #1 b_in_mode = 1'b1;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_y !== 8'h03 || b_out_mode !== 1'b0) begin
      errors++; $display("FAIL rotl_fwd: got v=%b y=%h m=%b required v=1 y=03 m=0", b_out_valid, b_out_y, b_out_mode);
    end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_y !== 8'h81 || b_out_mode !== 1'b1) begin
      errors++; $display("FAIL rotl_bwd: got v=%b y=%h m=%b required v=1 y=81 m=1", b_out_valid, b_out_y, b_out_mode);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_shares;
    bit sent;
    sent = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) c_send(24'($urandom), 1'($urandom_range(0, 1)));
        sent = 1'b1;
      end
      begin
        while (!sent) begin
          @(posedge clk);
          #1 c_in_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    c_in_ready = 1'b1;
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL shares_drain: %0d items left, required 0", sb.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int start;
    int rel_idx;
    c_in_ready = 1'b1;
    start   = out_cyc.size();
    rel_idx = start;
    fork
      begin
        for (int i = 0; i < 10; i++) c_send({8'(i * 17 + 1), 8'(i * 5 + 2), 8'(i)}, (i % 2) == 1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 c_in_ready = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (c_out_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b required 0", c_out_ready); end
        checks++; if (sb.size() != 3) begin errors++; $display("FAIL bp_held: got %0d held required 3", sb.size()); end
        @(posedge clk);
        #1 c_in_ready = 1'b1;
        rel_idx = out_cyc.size();
      end
    join
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    checks++; if (out_cyc.size() - start != 10) begin
      errors++; $display("FAIL bp_count: got %0d outputs required 10", out_cyc.size() - start);
    end
    for (int i = rel_idx + 1; i < out_cyc.size(); i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 1) begin
        errors++; $display("FAIL bp_gap: output %0d spacing %0d required 1", i - start, out_cyc[i] - out_cyc[i-1]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush;
    c_in_ready = 1'b0;
    c_send(24'h123456, 1'b0);
    c_send(24'hABCDEF, 1'b1);
    rst        = 1'b1;
    c_in_valid = 1'b1;
    c_in_x     = 24'h5A5A5A;
    c_in_ready = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    c_in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", c_out_valid); end
    checks++; if (c_out_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", c_out_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: cycle %0d got valid %b required 0", i, c_out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int start;
    c_in_ready = 1'b1;
    start = out_cyc.size();
    for (int i = 0; i < 8; i++) c_send(24'($urandom), (i % 2) == 1);
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    checks++; if (out_cyc.size() - start != 8) begin
      errors++; $display("FAIL b2b_count: got %0d outputs required 8", out_cyc.size() - start);
    end
    for (int i = start + 1; i < out_cyc.size(); i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 1) begin
        errors++; $display("FAIL b2b_gap: output %0d spacing %0d required 1", i - start, out_cyc[i] - out_cyc[i-1]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_x = '0; a_in_ready = 1'b1;
    b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_x = '0; b_in_ready = 1'b1;
    c_in_valid = 1'b0; c_in_mode = 1'b0; c_in_x = '0; c_in_ready = 1'b1;
    test_reset();
    test_identity();
    test_rotl();
    test_shares();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
